// File: rtl/io_display_pkg.sv
// Shared constants and types for the seven-segment display driver.
// The decimal conversion FSM is only built when IO_DISPLAY_DECIMAL_EN is defined.
package io_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam int REFRESH_DIV_DEFAULT = 50000;

  // Active-low {g,f,e,d,c,b,a} patterns for 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/io_display_driver_hex_to_7seg.sv
// Combinational 4-bit digit to active-low seven-segment pattern decoder.
module hex_to_7seg
  import io_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[digit];

endmodule

// File: rtl/io_display_driver.sv
// Latches a display value on Load and scans it onto a 4-digit active-low display.
// Define IO_DISPLAY_DECIMAL_EN for decimal (double-dabble) display instead of hex.
module io_display_driver
  import io_display_pkg::*;
#(
  parameter int N           = 8,
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Load,
  input  logic [N-1:0] Value,
  output logic         Busy,
  output logic [6:0]   Seg,
  output logic [3:0]   An,
  output logic         Dp
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          active_q, active_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    lit;
  logic          wrap;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;

`ifdef IO_DISPLAY_DECIMAL_EN
  localparam int SCW = $clog2(N + 1);

  conv_state_t    state_q, state_d;
  logic [15:0]    bcd_q, bcd_d, bcd_adj;
  logic [N-1:0]   bin_q, bin_d;
  logic [SCW-1:0] shift_cnt_q, shift_cnt_d;
  logic [3:0]     lit_q, lit_d;

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    shift_cnt_d = shift_cnt_q;
    digits_d    = digits_q;
    lit_d       = lit_q;
    bcd_adj     = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (Load) begin
          state_d     = SHIFT;
          bin_d       = Value;
          bcd_d       = '0;
          shift_cnt_d = '0;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        shift_cnt_d    = shift_cnt_q + SCW'(1);
        if (shift_cnt_q == SCW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        // Leading zeros go dark; the units digit is always shown
        digits_d = bcd_q;
        lit_d    = {bcd_q[15:12] != 4'd0, bcd_q[15:8] != 8'd0,
                    bcd_q[15:4] != 12'd0, 1'b1};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      shift_cnt_q <= '0;
      lit_q       <= 4'b0001;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      shift_cnt_q <= shift_cnt_d;
      lit_q       <= lit_d;
    end
  end

  assign lit  = lit_q;
  assign Busy = (state_q != IDLE);
`else
  localparam int         HEX_DIGITS = (N + 3) / 4;
  localparam logic [3:0] HEX_LIT    = 4'((1 << HEX_DIGITS) - 1);

  assign digits_d = Load ? 16'(Value) : digits_q;
  assign lit      = HEX_LIT;
  assign Busy     = 1'b0;
`endif

  assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  // Display stays dark until the first refresh wrap after reset
  always_comb begin
    wrap     = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
    active_d = active_q | wrap;
    seg_d    = SEG_BLANK;
    an_d     = AN_OFF;
    if (active_q && lit[idx_q]) begin
      seg_d = cur_seg;
      an_d  = ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= AN_OFF;
      digits_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      digits_q <= digits_d;
    end
  end

  assign Seg = seg_q;
  assign An  = an_q;
  assign Dp  = 1'b1;

endmodule

// File: tb/tb_io_display_driver.sv
// Bench for io_display_driver: per-cycle comparison against a value-level model
// of what each scanned digit should show, with directed and random loads.
module tb_io_display_driver;

  localparam int N  = 8;
  localparam int RD = 4;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [N-1:0] value;
  logic         busy;
  logic [6:0]   seg;
  logic [3:0]   an;
  logic         dp;

  io_display_driver #(.N(N), .REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Load  (load),
    .Value (value),
    .Busy  (busy),
    .Seg   (seg),
    .An    (an),
    .Dp    (dp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  int p10 [4] = '{1, 10, 100, 1000};

  int k;        // edges since reset release
  int shown;    // value held in the digit registers
  int cap;      // edge at which the last conversion was accepted
  int pend;     // value under conversion
  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t, edge %0d)", tag, obs, exp, $time, k);
    end
  endtask

  // What the pins should show given j edges of scanning and the stored value
  function automatic void expected(input int j, input int val,
                                   output logic [6:0] es, output logic [3:0] ea);
    int  idx;
    int  dv;
    bit  on;
    es = 7'h7F;
    ea = 4'hF;
    if (j >= RD) begin
      idx = (j / RD) % 4;
`ifdef IO_DISPLAY_DECIMAL_EN
      dv = (val / p10[idx]) % 10;
      on = (idx == 0) || (val >= p10[idx]);
`else
      dv = (val >> (4 * idx)) & 15;
      on = idx < (N + 3) / 4;
`endif
      if (on) begin
        es      = seg_tab[dv];
        ea      = 4'hF;
        ea[idx] = 1'b0;
      end
    end
  endfunction

  // driver: one clock with given inputs, update model, check at negedge
  task automatic cycle(input logic r, input logic ld, input logic [N-1:0] v);
    logic [6:0] es;
    logic [3:0] ea;
    logic       eb;
    int         prev;
    rst_n = r;
    load  = ld;
    value = v;
    @(posedge clk);
    prev = shown;
    if (!r) begin
      k     = 0;
      shown = 0;
      cap   = -1000;
    end else begin
      k++;
`ifdef IO_DISPLAY_DECIMAL_EN
      if (ld && !((k - 1) >= cap && (k - 1) <= cap + N)) begin
        cap  = k;
        pend = int'(v);
      end
      if (k == cap + N + 1) shown = pend;
`else
      if (ld) shown = int'(v);
`endif
    end
`ifdef IO_DISPLAY_DECIMAL_EN
    eb = r && (k >= cap) && (k <= cap + N);
`else
    eb = 1'b0;
`endif
    @(negedge clk);
    expected(r ? k - 1 : -1, prev, es, ea);
    chk("seg", 16'(seg), 16'(es));
    chk("an", 16'(an), 16'(ea));
    chk("busy", 16'(busy), 16'(eb));
    chk("dp", 16'(dp), 16'h1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    k           = 0;
    shown       = 0;
    cap         = -1000;
    pend        = 0;
    rst_n       = 1'b0;
    load        = 1'b0;
    value       = '0;

    repeat (3) cycle(1'b0, 1'b0, '0);
    idle(5 * RD);

    cycle(1'b1, 1'b1, 8'h3C);
    idle(5 * RD);

    cycle(1'b1, 1'b1, 8'hFF);
    idle(3);
    cycle(1'b1, 1'b1, 8'h07);
    idle(N + 5 * RD);

    cycle(1'b1, 1'b1, 8'h05);
    idle(N + 5 * RD);

    // reset lands on the 4th shift cycle of a conversion
    cycle(1'b1, 1'b1, 8'h90);
    idle(3);
    cycle(1'b0, 1'b0, '0);
    idle(RD + 2);
    cycle(1'b1, 1'b1, 8'h10);
    idle(N + 5 * RD);

    for (int i = 0; i < 60; i++) begin
      cycle($urandom_range(0, 79) != 0, 1'b1, N'($urandom));
      idle($urandom_range(0, 3 * RD));
    end
    idle(N + 5 * RD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_display_driver.md
Name: io_display_driver

Overview:
- Consumer end of the memory-mapped display port: receives the byte the CPU stores to the display address (253) and drives a 4-digit, time-multiplexed, active-low seven-segment display.
- Latches the value on a load strobe, converts it to digits, and scans the digits at a programmable refresh rate.
- Sits between the data-memory display output / store strobe and the board display pins.

Parameters:
- N, 8, width of the display value; legal 1..16 in hex mode, 1..13 in decimal mode.
- REFRESH_DIV, 50000, clk cycles each digit stays lit; legal >= 2; benches use 4.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset: synchronous, active-low
- Load  input  1  store strobe (CPU write to address 253), one cycle
- Value  input  N  value to display, sampled when Load is accepted
- Busy  output  1  conversion in progress; Load ignored while high
- Seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- An  output  4  digit enables, active-low, one-hot; An[0] = least significant digit
- Dp  output  1  decimal point, active-low; constant 1 (off)

Behaviour:
- Reset, when rst_n = 0 at a clk edge:
  - Seg = 7'h7F, An = 4'hF, Busy = 0, Dp = 1.
  - Digit registers = 0, refresh counter = 0, scan index = 0.
  - Any conversion in progress is aborted.
- Load acceptance:
  - Load = 1 and Busy = 0 at an edge captures Value.
  - Load while Busy = 1 is dropped, with no queueing.
- Hex mode (macro undefined):
  - Digit i = Value[4i+3:4i], zero-extended, updated on the capture edge.
  - Busy never asserts.
  - Digits with index >= ceil(N/4) are blanked (An bit held 1).
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index increments mod 4.
- Seg/An outputs:
  - Registered and recomputed every cycle from the scan index and digit registers, so one cycle latency from an index change.
  - A blanked digit drives An = 4'hF and Seg = 7'h7F.
- First lit output appears REFRESH_DIV+1 cycles after reset release.
- A new value appears on the current digit at the next register update; there is no tearing within a digit.
- Hex decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.

Optional Feature:
- Macro: IO_DISPLAY_DECIMAL_EN.
- Defined: decimal display via sequential double-dabble, with states IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on an accepted Load.
  - SHIFT lasts N cycles. Each cycle, every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1.
  - DONE lasts one cycle, copies the BCD nibbles into the digit registers, then returns to IDLE.
  - Busy = 1 in SHIFT and DONE, so Busy is high for N+1 cycles.
  - New digits are visible in the digit registers N+1 cycles after the capture edge.
  - Leading zeros are blanked; digit 0 always lit, including for value 0.
  - During conversion the display keeps showing the old value.
- Undefined: hex mode only; FSM and BCD logic are not built; Busy is tied 0.

Decomposition:
- Package io_display_pkg holds:
  - localparams SEG_BLANK = 7'h7F and AN_OFF = 4'hF
  - the 16-entry hex segment pattern table
  - the enum typedef conv_state_t {IDLE, SHIFT, DONE}
  - the default refresh constant
- One sub-module: hex_to_7seg, a purely combinational 4-bit to 7-bit active-low decoder, instantiated once on the muxed digit.

Test Plan (N = 8, REFRESH_DIV = 4):
1. Hold rst_n = 0 for 3 cycles, release -> Seg = 7F, An = F, Busy = 0 until the first scan update; all digits then show 0 or are blanked.
2. Hex mode, Load with Value = 0x3C -> when scanned:
   - An = 1110 with Seg = 46
   - An = 1101 with Seg = 30
   - An[3:2] never low
3. Decimal mode, Load with Value = 0xFF:
   - Busy high exactly 9 cycles; the old value is shown meanwhile.
   - Afterwards digits 0,1,2 show Seg = 12, 12, 24 (255); digit 3 blanked.
4. Decimal mode, Load 0xFF, then Load 0x07 three cycles later -> second Load ignored; final display 255.
5. Decimal mode, Value = 0x05 -> only An = 1110 lit, with Seg = 12; tens and hundreds blanked.
6. Decimal mode, rst_n = 0 during the 4th SHIFT cycle -> next cycle Busy = 0, Seg = 7F, An = F; a subsequent Load 0x10 converts cleanly to 16.
